// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- fetch-stage program-counter generator
//
// Holds the current fetch address and presents it to instruction memory over
// a valid/ready handshake. The PC advances by INSTR_BYTES on each accepted
// fetch. Traps and branch redirects change the PC even while the pipeline is
// stalled. An optional return-address stack supplies the target for returns.
//
// Configuration macro:
//   PC_GEN_RAS_EN  defined   -> return-address stack is built
//                  undefined -> no stack storage; i_ras_push, i_ras_push_pc
//                               and i_ras_pop are ignored, and
//                               o_ras_underflow is tied to 0
//
// Parameters:
//   ADDR_W       PC width in bits
//   RESET_VEC    PC value loaded on reset
//   INSTR_BYTES  sequential increment (2 or 4)
//   RAS_DEPTH    return-address-stack entries (power of two, >= 2)
//
// Ports:
//   i_clk             clock; all state changes on the rising edge
//   i_reset           asynchronous, active-low reset
//   i_stall           pipeline hold; blocks the sequential advance
//   i_fetch_ready     instruction memory accepts o_fetch_pc
//   o_fetch_valid     o_fetch_pc is a valid fetch request
//   o_fetch_pc        current PC (registered)
//   o_pc_plus         o_fetch_pc + INSTR_BYTES (combinational, wraps)
//   i_trap_valid      trap redirect; highest priority
//   i_trap_pc         trap target
//   i_redirect_valid  branch/jump redirect
//   i_redirect_pc     redirect target
//   i_ras_push        push i_ras_push_pc onto the return stack (call)
//   i_ras_push_pc     return address to push
//   i_ras_pop         use the top of the stack as the next PC (return)
//   o_misalign        one-cycle pulse: the applied target had low bits set
//   o_ras_underflow   one-cycle pulse: a pop was consumed on an empty stack
//   o_fetch_count     number of accepted fetches (wraps)
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter int unsigned       INSTR_BYTES = 4,
    parameter int unsigned       RAS_DEPTH   = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stall,
    input  logic              i_fetch_ready,
    output logic              o_fetch_valid,
    output logic [ADDR_W-1:0] o_fetch_pc,
    output logic [ADDR_W-1:0] o_pc_plus,
    input  logic              i_trap_valid,
    input  logic [ADDR_W-1:0] i_trap_pc,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_ras_push,
    input  logic [ADDR_W-1:0] i_ras_push_pc,
    input  logic              i_ras_pop,
    output logic              o_misalign,
    output logic              o_ras_underflow,
    output logic [31:0]       o_fetch_count
);

    // -----------------------------------------------------------------------
    // Parameter sanity checks (elaboration time only)
    // -----------------------------------------------------------------------
    if (!(INSTR_BYTES == 2 || INSTR_BYTES == 4)) begin : g_bad_instr_bytes
        $error("pc_gen: INSTR_BYTES must be 2 or 4");
    end
    if (RAS_DEPTH < 2 || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_ras_depth
        $error("pc_gen: RAS_DEPTH must be a power of two >= 2");
    end

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INSTR_BYTES);

    // Clear the low address bits that an instruction boundary cannot have.
    function automatic logic [ADDR_W-1:0] f_align(input logic [ADDR_W-1:0] a);
        return a & ~ALIGN_MASK;
    endfunction

    function automatic logic f_misaligned(input logic [ADDR_W-1:0] a);
        return |(a & ALIGN_MASK);
    endfunction

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_armed;
    logic   w_fetch_valid;

    // Reset is released asynchronously, so the first rising edge after
    // release only arms the FSM. BOOT then holds for one full clock cycle,
    // and the first fetch request appears after the second edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_BOOT;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_fetch_valid = 1'b0;
        case (r_state)
            S_BOOT: begin
                if (r_armed) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_fetch_valid = 1'b1;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Redirect / accept qualification
    // -----------------------------------------------------------------------
    logic              w_run;
    logic              w_accept;
    logic              w_take_trap;
    logic              w_take_redir;
    logic              w_redirect_any;
    logic              w_count_inc;
    logic              w_pop_req;
    logic              w_pop_hit;
    logic              w_pop_under;
    logic              w_ras_empty;
    logic [ADDR_W-1:0] w_ras_top;

    assign w_run          = (r_state == S_RUN);
    assign w_accept       = w_fetch_valid & i_fetch_ready & ~i_stall;
    assign w_take_trap    = w_run & i_trap_valid;
    assign w_take_redir   = w_run & ~i_trap_valid & i_redirect_valid;
    assign w_redirect_any = w_take_trap | w_take_redir;

    // A trap or redirect drops the request currently on the bus, so that
    // fetch is not counted even if memory signalled ready.
    assign w_count_inc    = w_accept & ~w_redirect_any;

    assign w_pop_hit      = w_pop_req & ~w_ras_empty;
    assign w_pop_under    = w_pop_req & w_ras_empty;

    // -----------------------------------------------------------------------
    // Return-address stack
    // -----------------------------------------------------------------------
`ifdef PC_GEN_RAS_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Circular buffer: r_ras_ptr indexes the top entry. A push on a full
    // stack wraps the pointer onto the oldest entry, which is overwritten.
    logic [ADDR_W-1:0] r_ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ras_ptr;
    logic [CNT_W-1:0]  r_ras_cnt;
    logic [PTR_W-1:0]  w_ras_ptr_inc;
    logic [PTR_W-1:0]  w_ras_ptr_dec;
    logic              w_ras_full;

    // A pop is consumed only on an accepted fetch with no trap or redirect.
    assign w_pop_req     = i_ras_pop & w_count_inc;
    assign w_ras_empty   = (r_ras_cnt == '0);
    assign w_ras_full    = (r_ras_cnt == CNT_W'(RAS_DEPTH));
    assign w_ras_top     = r_ras_mem[r_ras_ptr];
    assign w_ras_ptr_inc = r_ras_ptr + PTR_W'(1);
    assign w_ras_ptr_dec = r_ras_ptr - PTR_W'(1);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                r_ras_mem[i] <= '0;
            end
        end else begin
            if (i_ras_push && w_pop_hit) begin
                // Call and return in the same cycle: the return consumes the
                // old top, and the new return address takes its slot.
                r_ras_mem[r_ras_ptr] <= i_ras_push_pc;
            end else if (i_ras_push) begin
                r_ras_mem[w_ras_ptr_inc] <= i_ras_push_pc;
                r_ras_ptr                <= w_ras_ptr_inc;
                if (!w_ras_full) begin
                    r_ras_cnt <= r_ras_cnt + CNT_W'(1);
                end
            end else if (w_pop_hit) begin
                r_ras_ptr <= w_ras_ptr_dec;
                r_ras_cnt <= r_ras_cnt - CNT_W'(1);
            end
        end
    end
`else
    logic w_unused_ras;

    assign w_pop_req    = 1'b0;
    assign w_ras_empty  = 1'b1;
    assign w_ras_top    = '0;
    assign w_unused_ras = ^{i_ras_push, i_ras_push_pc, i_ras_pop};
`endif

    // -----------------------------------------------------------------------
    // Next-PC selection
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_plus;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_target;
    logic              w_apply;
    logic              w_misalign_nxt;
    logic              r_misalign;
    logic              r_underflow;
    logic [31:0]       r_count;

    assign w_pc_plus = r_pc + PC_INC;

    always_comb begin
        w_target       = '0;
        w_apply        = 1'b0;
        w_pc_nxt       = r_pc;
        w_misalign_nxt = 1'b0;

        if (w_take_trap) begin
            w_target = i_trap_pc;
            w_apply  = 1'b1;
        end else if (w_take_redir) begin
            w_target = i_redirect_pc;
            w_apply  = 1'b1;
        end else if (w_pop_hit) begin
            w_target = w_ras_top;
            w_apply  = 1'b1;
        end

        if (w_apply) begin
            w_pc_nxt       = f_align(w_target);
            w_misalign_nxt = f_misaligned(w_target);
        end else if (w_count_inc) begin
            // Sequential advance; a pop on an empty stack lands here too.
            w_pc_nxt = w_pc_plus;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pc        <= RESET_VEC;
            r_misalign  <= 1'b0;
            r_underflow <= 1'b0;
            r_count     <= '0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_misalign  <= w_misalign_nxt;
            r_underflow <= w_pop_under;
            if (w_count_inc) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_fetch_valid   = w_fetch_valid;
    assign o_fetch_pc      = r_pc;
    assign o_pc_plus       = w_pc_plus;
    assign o_misalign      = r_misalign;
    assign o_ras_underflow = r_underflow;
    assign o_fetch_count   = r_count;

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen
//
// The driver applies stimulus on the falling clock edge. It advances a
// behavioural model and queues the outputs expected after the next rising
// edge. A separate monitor pops one expectation per rising edge (and one per
// asynchronous reset assertion) and compares it with the DUT outputs.
// The bench follows the PC_GEN_RAS_EN macro, so it checks either build.
// ---------------------------------------------------------------------------
module tb_pc_gen;

    localparam int          AW    = 32;
    localparam logic [31:0] RV    = 32'h0000_0100;
    localparam int          IB    = 4;
    localparam int          DEPTH = 4;
`ifdef PC_GEN_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, ready, trap, redir, push, pop;
    logic [AW-1:0] tpc, rpc, ppc;
    logic          fetch_valid, misalign, underflow;
    logic [AW-1:0] fetch_pc, pc_plus;
    logic [31:0]   fetch_count;

    pc_gen #(
        .ADDR_W      (AW),
        .RESET_VEC   (RV),
        .INSTR_BYTES (IB),
        .RAS_DEPTH   (DEPTH)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_stall          (stall),
        .i_fetch_ready    (ready),
        .o_fetch_valid    (fetch_valid),
        .o_fetch_pc       (fetch_pc),
        .o_pc_plus        (pc_plus),
        .i_trap_valid     (trap),
        .i_trap_pc        (tpc),
        .i_redirect_valid (redir),
        .i_redirect_pc    (rpc),
        .i_ras_push       (push),
        .i_ras_push_pc    (ppc),
        .i_ras_pop        (pop),
        .o_misalign       (misalign),
        .o_ras_underflow  (underflow),
        .o_fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] plus;
        logic        mis;
        logic        und;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // ---------------- behavioural reference model ----------------
    // m_phase counts rising edges seen since reset release, saturating at 2.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_mis;
    logic        m_und;
    logic [31:0] m_ras[$];   // newest entry at the back

    function automatic exp_t m_out();
        exp_t e;
        e.valid = (m_phase == 2);
        e.pc    = m_pc;
        e.plus  = m_pc + 32'(IB);
        e.mis   = m_mis;
        e.und   = m_und;
        e.cnt   = m_cnt;
        return e;
    endfunction

    task automatic m_reset();
        m_phase = 0;
        m_pc    = RV;
        m_cnt   = 0;
        m_mis   = 1'b0;
        m_und   = 1'b0;
        m_ras.delete();
    endtask

    task automatic m_apply(input logic [31:0] t);
        m_pc  = t & ~32'(IB - 1);
        m_mis = (t & 32'(IB - 1)) != 0;
    endtask

    // One rising edge of the reference, using the currently driven inputs.
    task automatic m_edge();
        bit          pop_hit;
        logic [31:0] dummy;
        pop_hit = 1'b0;
        if (!rst_n) begin
            m_reset();
            return;
        end
        m_mis = 1'b0;
        m_und = 1'b0;
        if (m_phase < 2) begin
            m_phase++;
        end else if (trap) begin
            m_apply(tpc);
        end else if (redir) begin
            m_apply(rpc);
        end else if (ready && !stall) begin
            m_cnt = m_cnt + 1;
            if (RAS_ON && pop && m_ras.size() > 0) begin
                pop_hit = 1'b1;
                m_apply(m_ras[m_ras.size() - 1]);
            end else begin
                if (RAS_ON && pop) m_und = 1'b1;
                m_pc = m_pc + 32'(IB);
            end
        end
        if (RAS_ON && push) begin
            if (pop_hit) begin
                m_ras[m_ras.size() - 1] = ppc;
            end else begin
                m_ras.push_back(ppc);
                if (m_ras.size() > DEPTH) dummy = m_ras.pop_front();
            end
        end else if (pop_hit) begin
            dummy = m_ras.pop_back();
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic idle();
        stall = 1'b0; ready = 1'b1; trap = 1'b0; redir = 1'b0;
        push  = 1'b0; pop   = 1'b0; tpc  = '0;   rpc   = '0; ppc = '0;
    endtask

    task automatic tick();
        m_edge();
        q.push_back(m_out());
        @(negedge clk);
    endtask

    // Assert reset between clock edges; outputs must change before any edge.
    task automatic async_reset();
        #2;
        m_reset();
        q.push_back(m_out());   // immediately after assertion
        q.push_back(m_out());   // after the next rising edge, still in reset
        rst_n = 1'b0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(posedge clk or negedge rst_n) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            n_tests++;
            if ({fetch_valid, fetch_pc, pc_plus, misalign, underflow, fetch_count} !== mon_e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got v=%0b pc=%h plus=%h mis=%0b und=%0b cnt=%0d, expected v=%0b pc=%h plus=%h mis=%0b und=%0b cnt=%0d",
                         $time, fetch_valid, fetch_pc, pc_plus, misalign, underflow, fetch_count,
                         mon_e.valid, mon_e.pc, mon_e.plus, mon_e.mis, mon_e.und, mon_e.cnt);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        idle();
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        tick(); tick();                    // reset held

        // release; BOOT, then 0x100, 0x104, 0x108
        rst_n = 1'b1;
        repeat (4) tick();

        // stall three cycles at 0x108, then advance to 0x10C
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        tick();

        // trap beats redirect, both override the stall
        stall = 1'b1; trap = 1'b1; tpc = 32'h8000; redir = 1'b1; rpc = 32'h2000;
        tick();
        trap = 1'b0; rpc = 32'h2003;       // misaligned redirect
        tick();
        idle();
        tick();

        // stack: five pushes while stalled, then five returns
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; ppc = 32'hA0 + 32'(i) * 32'h10;
            tick();
        end
        idle(); pop = 1'b1;
        repeat (5) tick();
        idle();

        // push and pop in the same cycle
        stall = 1'b1; push = 1'b1; ppc = 32'h40;
        tick();
        stall = 1'b0; push = 1'b1; ppc = 32'h50; pop = 1'b1;
        tick();
        push = 1'b0;
        tick();
        idle();
        tick();

        // address wrap
        ready = 1'b0; redir = 1'b1; rpc = 32'hFFFF_FFFC;
        tick();
        idle();
        repeat (2) tick();

        // reset mid-stream
        async_reset();
        repeat (3) tick();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            stall = ($urandom % 5) == 0;
            ready = ($urandom % 4) != 0;
            trap  = ($urandom % 40) == 0;
            redir = ($urandom % 15) == 0;
            tpc   = $urandom;
            rpc   = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
            push  = (m_phase == 2) && (($urandom % 6) == 0);
            ppc   = $urandom;
            pop   = ($urandom % 5) == 0;
            tick();
            if (i == 1000) begin
                idle();
                async_reset();
            end
        end
        idle();
        repeat (2) tick();

        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage, replacing the bare PC register. Holds the current fetch address, presents it to instruction memory over a valid/ready handshake, and advances sequentially on acceptance. Supports prioritised redirects (trap, branch, return-stack pop) with stall override and a configurable reset vector. An optional return-address stack predicts return targets.

## Interface
- ADDR_W, 32: PC width in bits
- RESET_VEC, 32'h0000_0000: PC value loaded on reset
- INSTR_BYTES, 4: sequential increment; power of two, 2 or 4
- RAS_DEPTH, 4: return-address-stack entries; power of two, ≥2
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_stall  in  1  pipeline hold; blocks sequential advance
- i_fetch_ready  in  1  instruction memory accepts o_fetch_pc
- o_fetch_valid  out  1  o_fetch_pc is a valid fetch request
- o_fetch_pc  out  ADDR_W  current PC, registered
- o_pc_plus  out  ADDR_W  o_fetch_pc + INSTR_BYTES, combinational, modulo 2^ADDR_W
- i_trap_valid  in  1  trap/exception redirect, highest priority
- i_trap_pc  in  ADDR_W  trap target
- i_redirect_valid  in  1  branch/jump redirect
- i_redirect_pc  in  ADDR_W  redirect target
- i_ras_push  in  1  push i_ras_push_pc (call)
- i_ras_push_pc  in  ADDR_W  return address to push
- i_ras_pop  in  1  use top-of-stack as next PC (return)
- o_misalign  out  1  one-cycle pulse: applied target had nonzero low bits
- o_ras_underflow  out  1  one-cycle pulse: pop on empty stack
- o_fetch_count  out  32  count of accepted fetches, wraps

## Operation
- FSM states: BOOT, RUN. Reset → BOOT. BOOT → RUN unconditionally next cycle. RUN has no exit except reset.
- BOOT: o_fetch_valid=0, o_fetch_pc=RESET_VEC, no redirects taken (redirect inputs ignored).
- RUN: o_fetch_valid=1. Accept = o_fetch_valid & i_fetch_ready & ~i_stall.
- Next-PC priority in RUN: i_trap_valid > i_redirect_valid > (i_ras_pop & accept) > accept sequential (o_pc_plus) > hold.
- Trap and redirect override i_stall and ignore i_fetch_ready; current request is dropped, not counted.
- Hold: o_fetch_pc stable while valid and not accepted (valid/ready rule), unless trap/redirect.
- Targets (trap, redirect, RAS): low log2(INSTR_BYTES) bits forced to 0; o_misalign pulses next cycle if any were set.
- o_fetch_count increments by 1 on every accept (including pops); wraps 2^32−1 → 0.
- RAS: circular buffer, pointer + occupancy count. Push on full overwrites oldest, occupancy stays RAS_DEPTH. Pop on empty: sequential advance, o_ras_underflow pulses. Push and pop same cycle: top entry replaced, occupancy unchanged, next PC = old top. Pop consumed only when accepted and no higher-priority redirect; push always takes effect.
- Trap does not clear RAS.

## Timing
- Reset values: o_fetch_valid=0, o_fetch_pc=RESET_VEC, o_misalign=0, o_ras_underflow=0, o_fetch_count=0, RAS empty; o_pc_plus=RESET_VEC+INSTR_BYTES.
- First fetch request: o_fetch_valid rises on second rising edge after reset deassertion (BOOT occupies one cycle).
- Redirect/trap sampled at edge n → o_fetch_pc = target after edge n, one-cycle latency.
- Sequential: accept at edge n → o_fetch_pc = old+INSTR_BYTES after edge n; back-to-back accepts give one address per cycle.
- PC wraps 2^ADDR_W−INSTR_BYTES → 0 with no flag.
- Reset asserted mid-operation: all state returns immediately (asynchronously) to reset values; RAS contents discarded.

## Configuration
- PC_GEN_RAS_EN defined: return-address stack built as above.
- Undefined: no stack storage; i_ras_push, i_ras_push_pc, i_ras_pop ignored; pop never changes next PC; o_ras_underflow tied 0.

## Test plan
- Reset release, i_fetch_ready=1, RESET_VEC=0x100, INSTR_BYTES=4 -> valid low 1 cycle, then fetch PCs 0x100, 0x104, 0x108; count 0,1,2,...
- i_stall=1 for 3 cycles at PC 0x108 -> o_fetch_pc held 0x108, count frozen; release -> 0x10C.
- Same-cycle i_trap_valid (0x8000) and i_redirect_valid (0x2000) with i_stall=1 -> next PC 0x8000; redirect to 0x2003 -> PC 0x2000, o_misalign pulse.
- PC_GEN_RAS_EN, RAS_DEPTH=4: push 0xA0,0xB0,0xC0,0xD0,0xE0, five pops -> PCs 0xE0,0xD0,0xC0,0xB0, then sequential with o_ras_underflow pulse.
- Push+pop same cycle with top 0x40, push 0x50 -> next PC 0x40, next pop yields 0x50.
- PC=0xFFFF_FFFC accepted -> 0x0000_0000; reset asserted mid-stream -> immediate RESET_VEC, valid 0, count 0.
